// File: rtl/mmio_timer_bank.sv
// mmio_timer_bank
//   Bank of N_TIMERS independent down-counting timers on the MMIO bus. Each
//   channel has a prescaler, one-shot/periodic mode and an interrupt enable.
//   Channels share a sticky write-1-to-clear status register and a read-only
//   ID register.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   we       write strobe, one cycle per access
//   be       byte enables for wdata
//   addr     local byte address (addr[1:0] ignored)
//   wdata    write data
//   rdata    read data, combinational from addr
//   irq      per-channel interrupt, status & IE (registered)
//   irq_any  OR of irq
//
// Map
//   addr[7]=0 : ch=addr[6:4], reg=addr[3:2] -> 0 CTRL, 1 LOAD, 2 COUNT(RO), 3 PRESC
//   0x80      : STATUS (W1C)
//   0x84      : ID = {16'h0, N_TIMERS[7:0], CNT_W[7:0]}
module mmio_timer_bank #(
  parameter int unsigned N_TIMERS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESC_W  = 8,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [3:0]          be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [N_TIMERS-1:0] irq,
  output logic                irq_any
);

  logic [N_TIMERS-1:0] en_q, en_d;
  logic [N_TIMERS-1:0] ie_q, ie_d;
  logic [N_TIMERS-1:0] os_q, os_d;
  logic [N_TIMERS-1:0] status_q, status_d;
  logic [N_TIMERS-1:0] irq_q;
  logic [CNT_W-1:0]    load_q  [N_TIMERS];
  logic [CNT_W-1:0]    load_d  [N_TIMERS];
  logic [CNT_W-1:0]    cnt_q   [N_TIMERS];
  logic [CNT_W-1:0]    cnt_d   [N_TIMERS];
  logic [PRESC_W-1:0]  presc_q [N_TIMERS];
  logic [PRESC_W-1:0]  presc_d [N_TIMERS];
  logic [PRESC_W-1:0]  pcnt_q  [N_TIMERS];
  logic [PRESC_W-1:0]  pcnt_d  [N_TIMERS];

  logic [N_TIMERS-1:0] set_v;
  logic [N_TIMERS-1:0] clr_v;

  // Address decode
  logic [31:0] ch_w;
  logic [1:0]  reg_sel;
  logic        is_ch, is_status, is_id;
  logic        unused_addr;

  assign ch_w        = {29'b0, addr[6:4]};
  assign reg_sel     = addr[3:2];
  assign is_ch       = ~addr[7];
  assign is_status   = addr[7] && (addr[6:2] == 5'd0);
  assign is_id       = addr[7] && (addr[6:2] == 5'd1);
  assign unused_addr = ^addr[1:0];

  // Byte-lane merge of a write into a zero-extended register value
  function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  lanes);
    logic [31:0] r;
    r[7:0]   = lanes[0] ? new_v[7:0]   : old_v[7:0];
    r[15:8]  = lanes[1] ? new_v[15:8]  : old_v[15:8];
    r[23:16] = lanes[2] ? new_v[23:16] : old_v[23:16];
    r[31:24] = lanes[3] ? new_v[31:24] : old_v[31:24];
    return r;
  endfunction

  always_comb begin
    logic tick, hit, wr_ctrl, wr_load, wr_presc, restart;
    en_d    = en_q;
    ie_d    = ie_q;
    os_d    = os_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    set_v   = '0;
    tick     = 1'b0;
    hit      = 1'b0;
    wr_ctrl  = 1'b0;
    wr_load  = 1'b0;
    wr_presc = 1'b0;
    restart  = 1'b0;

    for (int unsigned i = 0; i < N_TIMERS; i++) begin
      hit      = we && is_ch && (ch_w == i);
      wr_ctrl  = hit && be[0] && (reg_sel == 2'd0);
      wr_load  = hit && (reg_sel == 2'd1);
      wr_presc = hit && (reg_sel == 2'd3);
      restart  = wr_ctrl && ((wdata[0] && !en_q[i]) || wdata[3]);
      tick     = en_q[i] && (pcnt_q[i] == presc_q[i]);

      if (en_q[i]) begin
        pcnt_d[i] = tick ? '0 : pcnt_q[i] + PRESC_W'(1);
      end

      // A restart in the same cycle discards the tick entirely: no decrement,
      // no expiry, no one-shot disable.
      if (tick && !restart) begin
        if (cnt_q[i] == '0) begin
          set_v[i] = 1'b1;
          cnt_d[i] = load_q[i];
          if (os_q[i]) en_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end

      // Software CTRL write overrides the one-shot auto-disable.
      if (wr_ctrl) begin
        en_d[i] = wdata[0];
        ie_d[i] = wdata[1];
        os_d[i] = wdata[2];
      end

      if (restart) begin
        cnt_d[i]  = load_q[i];
        pcnt_d[i] = '0;
      end

      if (wr_load) begin
        load_d[i] = CNT_W'(merge32(32'(load_q[i]), wdata, be));
      end
      if (wr_presc) begin
        presc_d[i] = PRESC_W'(merge32(32'(presc_q[i]), wdata, be));
      end
    end

    clr_v    = (we && be[0] && is_status) ? wdata[N_TIMERS-1:0] : '0;
    // Set wins over a same-cycle clear.
    status_d = (status_q & ~clr_v) | set_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= '0;
      ie_q     <= '0;
      os_q     <= '0;
      status_q <= '0;
      irq_q    <= '0;
      for (int unsigned i = 0; i < N_TIMERS; i++) begin
        load_q[i]  <= '0;
        cnt_q[i]   <= '0;
        presc_q[i] <= '0;
        pcnt_q[i]  <= '0;
      end
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      os_q     <= os_d;
      status_q <= status_d;
      irq_q    <= status_q & ie_q;
      for (int unsigned i = 0; i < N_TIMERS; i++) begin
        load_q[i]  <= load_d[i];
        cnt_q[i]   <= cnt_d[i];
        presc_q[i] <= presc_d[i];
        pcnt_q[i]  <= pcnt_d[i];
      end
    end
  end

  assign irq     = irq_q;
  assign irq_any = |irq_q;

  always_comb begin
    rdata = '0;
    if (is_ch) begin
      for (int unsigned i = 0; i < N_TIMERS; i++) begin
        if (ch_w == i) begin
          case (reg_sel)
            2'd0:    rdata = {29'b0, os_q[i], ie_q[i], en_q[i]};
            2'd1:    rdata = 32'(load_q[i]);
            2'd2:    rdata = 32'(cnt_q[i]);
            default: rdata = 32'(presc_q[i]);
          endcase
        end
      end
    end else if (is_status) begin
      rdata = 32'(status_q);
    end else if (is_id) begin
      rdata = {16'h0, 8'(N_TIMERS), 8'(CNT_W)};
    end
  end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank (N_TIMERS=4, CNT_W=32, PRESC_W=8).
// Inputs are driven 1 time unit after the rising edge; outputs sampled in
// the same phase.
module tb_mmio_timer_bank;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  be;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  irq;
  logic        irq_any;

  int total = 0;
  int bad   = 0;

  mmio_timer_bank #(
    .N_TIMERS(4),
    .CNT_W   (32),
    .PRESC_W (8),
    .ADDR_W  (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .be     (be),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq),
    .irq_any(irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [7:0]  waddr;
    logic [31:0] wdat;
    logic [3:0]  wbe;
    logic [7:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic do_wr, input logic [7:0] wa,
                              input logic [31:0] wd, input logic [3:0] wb,
                              input logic [7:0] ra, input logic [31:0] ex,
                              input string nm);
    vec_t v;
    v.do_wr = do_wr; v.waddr = wa; v.wdat = wd; v.wbe = wb;
    v.raddr = ra; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; be = 4'h0;
  endtask

  task automatic chk_rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; be = 4'h0; addr = 8'h00; wdata = '0;

    // Register-level vectors: {write?, waddr, wdata, be, raddr, expected}
    add(1, 8'h04, 32'hAABBCCDD, 4'hF, 8'h04, 32'hAABBCCDD, "load_full");
    add(1, 8'h04, 32'h11223344, 4'h4, 8'h04, 32'hAA22CCDD, "load_lane2");
    add(1, 8'h04, 32'h55667788, 4'h1, 8'h04, 32'hAA22CC88, "load_lane0");
    add(1, 8'h0C, 32'h00001234, 4'h3, 8'h0C, 32'h00000034, "presc_trunc");
    add(1, 8'h0C, 32'h0000FF00, 4'h2, 8'h0C, 32'h00000034, "presc_hi_lane");
    add(1, 8'h50, 32'h00000007, 4'hF, 8'h50, 32'h00000000, "ch5_ctrl");
    add(1, 8'h54, 32'h00001234, 4'hF, 8'h54, 32'h00000000, "ch5_load");
    add(0, 8'h00, 32'h00000000, 4'h0, 8'h84, 32'h00000420, "id");
    add(1, 8'h84, 32'hFFFFFFFF, 4'hF, 8'h84, 32'h00000420, "id_ro");
    add(0, 8'h00, 32'h00000000, 4'h0, 8'h88, 32'h00000000, "unmapped");
    add(1, 8'h10, 32'h00000006, 4'h1, 8'h10, 32'h00000006, "ctrl_ie_os");
    add(1, 8'h10, 32'h0000000F, 4'h0, 8'h10, 32'h00000006, "ctrl_no_be0");
    add(1, 8'h10, 32'h00000000, 4'h1, 8'h10, 32'h00000000, "ctrl_clear");
    add(0, 8'h00, 32'h00000000, 4'h0, 8'h08, 32'h00000000, "count_idle");
    add(1, 8'h18, 32'h00000055, 4'hF, 8'h18, 32'h00000000, "count_ro");
    add(1, 8'h1C, 32'h000000FF, 4'h1, 8'h1C, 32'h000000FF, "presc_ff");
    add(1, 8'h20, 32'h0000000A, 4'h1, 8'h20, 32'h00000002, "restart_rd0");
    add(1, 8'h20, 32'h00000000, 4'h1, 8'h20, 32'h00000000, "ch2_ctrl_off");

    // Reset state
    #1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_irq_any", 32'(irq_any), 32'h0);
    chk_rd("rst_status", 8'h80, 32'h0);
    chk_rd("rst_ctrl0", 8'h00, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdat, vecs[i].wbe);
      chk_rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end

    // Periodic: ch1 LOAD=3, PRESC=1 -> period 8
    wr(8'h14, 32'd3, 4'hF);
    wr(8'h1C, 32'd1, 4'hF);
    wr(8'h10, 32'h3, 4'h1);            // E0
    tick(7);
    chk_rd("per_before", 8'h80, 32'h0);
    tick(1);                           // E8
    chk_rd("per_set", 8'h80, 32'h2);
    chk("per_irq_lag", 32'(irq), 32'h0);
    tick(1);
    chk("per_irq", 32'(irq), 32'h2);
    chk("per_irq_any", 32'(irq_any), 32'h1);
    wr(8'h80, 32'h2, 4'h1);            // E10
    chk_rd("per_w1c", 8'h80, 32'h0);
    chk("per_irq_hold", 32'(irq), 32'h2);
    tick(1);
    chk("per_irq_drop", 32'(irq), 32'h0);
    tick(4);
    chk_rd("per_before2", 8'h80, 32'h0);
    tick(1);                           // E16
    chk_rd("per_set2", 8'h80, 32'h2);
    wr(8'h10, 32'h0, 4'h1);
    wr(8'h80, 32'h2, 4'h1);

    // One-shot: ch0 LOAD=5, PRESC=0
    wr(8'h04, 32'd5, 4'hF);
    wr(8'h0C, 32'd0, 4'hF);
    wr(8'h00, 32'h7, 4'h1);            // E0
    tick(5);
    chk_rd("os_before", 8'h80, 32'h0);
    chk_rd("os_cnt0", 8'h08, 32'h0);
    tick(1);                           // E6
    chk_rd("os_set", 8'h80, 32'h1);
    chk_rd("os_en_clr", 8'h00, 32'h6);
    chk_rd("os_reload", 8'h08, 32'h5);
    tick(1);
    chk("os_irq", 32'(irq), 32'h1);
    wr(8'h00, 32'h4, 4'h1);            // clear IE
    chk("ie_irq_hold", 32'(irq), 32'h1);
    tick(1);
    chk("ie_irq_drop", 32'(irq), 32'h0);
    chk_rd("ie_status_kept", 8'h80, 32'h1);
    wr(8'h80, 32'h1, 4'h1);
    tick(50);
    chk_rd("os_no_reset", 8'h80, 32'h0);
    chk_rd("os_cnt_held", 8'h08, 32'h5);

    // One-shot expiry colliding with software EN=1: software wins
    wr(8'h04, 32'd1, 4'hF);
    wr(8'h00, 32'h5, 4'h1);            // E0
    tick(1);
    wr(8'h00, 32'h5, 4'h1);            // E2 expiry
    chk_rd("os_sw_en", 8'h00, 32'h5);
    chk_rd("os_sw_status", 8'h80, 32'h1);
    chk_rd("os_sw_cnt", 8'h08, 32'h1);
    wr(8'h00, 32'h0, 4'h1);
    wr(8'h80, 32'h1, 4'h1);

    // Set/clear collision: ch2 LOAD=2, PRESC=0 -> expiries at E3, E6, E9
    wr(8'h24, 32'd2, 4'hF);
    wr(8'h20, 32'h1, 4'h1);            // E0
    tick(3);
    chk_rd("col_first", 8'h80, 32'h4);
    tick(2);
    wr(8'h80, 32'h4, 4'h1);            // E6
    chk_rd("col_set_wins", 8'h80, 32'h4);
    wr(8'h80, 32'h4, 4'h1);            // E7
    chk_rd("col_clear", 8'h80, 32'h0);
    wr(8'h20, 32'h0, 4'h1);            // E8
    tick(2);
    chk_rd("col_stopped", 8'h80, 32'h0);

    // Restart: ch3 LOAD=4, PRESC=2 -> ticks every 3 cycles
    wr(8'h34, 32'd4, 4'hF);
    wr(8'h3C, 32'd2, 4'hF);
    wr(8'h30, 32'h1, 4'h1);            // E0
    tick(6);
    chk_rd("rs_cnt2", 8'h38, 32'h2);
    wr(8'h30, 32'h9, 4'h1);            // E7
    chk_rd("rs_reload", 8'h38, 32'h4);
    tick(2);
    wr(8'h30, 32'h9, 4'h1);            // E10, same edge as a tick
    chk_rd("rs_prio", 8'h38, 32'h4);
    tick(14);
    chk_rd("rs_before", 8'h80, 32'h0);
    tick(1);                           // E25
    chk_rd("rs_expire", 8'h80, 32'h8);
    wr(8'h30, 32'h3, 4'h1);
    tick(1);
    chk("rs_irq", 32'(irq), 32'h8);
    chk("rs_irq_any", 32'(irq_any), 32'h1);

    // Asynchronous reset mid-cycle
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_irq_any", 32'(irq_any), 32'h0);
    chk_rd("arst_ctrl3", 8'h30, 32'h0);
    chk_rd("arst_load3", 8'h34, 32'h0);
    chk_rd("arst_cnt3", 8'h38, 32'h0);
    chk_rd("arst_presc3", 8'h3C, 32'h0);
    chk_rd("arst_status", 8'h80, 32'h0);
    chk_rd("arst_load0", 8'h04, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
